// File: rtl/robertson_mult_ctrl.sv
// Purpose : sequential signed multiplier (Robertson add/shift) with IDLE/CALC/DONE control.
// Latency : dw CALC cycles, then a one-cycle DONE; done is high dw+1 cycles after the start edge.
// Backpressure: none; start is accepted only in IDLE or DONE and ignored while busy.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset; aborts any multiplication, no done pulse
//   start         begin a multiplication (taken in IDLE/DONE only)
//   multiplicand  signed operand M, dw bits
//   multiplier    signed operand Q, dw bits
//   busy          high in CALC only
//   done          one-cycle pulse in DONE
//   product       {A, Q}, 2*dw bits, valid from DONE until the next accepted start
//
// Build option: define ROBERTSON_ZERO_SKIP_EN to finish immediately when either
// operand is zero (straight to DONE with product 0, busy never raised).

module robertson_mult_ctrl #(
  parameter int dw = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [dw-1:0]   multiplicand,
  input  logic [dw-1:0]   multiplier,
  output logic            busy,
  output logic            done,
  output logic [2*dw-1:0] product
);

  localparam int CW = (dw > 2) ? $clog2(dw) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(dw - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [dw-1:0]   a_q, a_d;
  logic [dw-1:0]   q_q, q_d;
  logic [dw-1:0]   m_q, m_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // One dw+1 bit add/subtract covers every step. The extra bit keeps the
  // sign of A correct even when M = -2^(dw-1), so no step can overflow.
  logic [dw:0] a_ext;
  logic [dw:0] m_sel;
  logic [dw:0] sum;
  logic        last_step;

  assign a_ext     = {a_q[dw-1], a_q};
  assign m_sel     = q_q[0] ? {m_q[dw-1], m_q} : '0;
  assign last_step = (cnt_q == CNT_LAST);
  // The multiplier's sign bit carries weight -2^(dw-1), so the final step subtracts.
  assign sum       = last_step ? (a_ext - m_sel) : (a_ext + m_sel);

  assign product = {a_q, q_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          cnt_d   = '0;
          state_d = CALC;
`ifdef ROBERTSON_ZERO_SKIP_EN
          // A zero operand gives a zero product; skip the shift sequence.
          if ((multiplicand == '0) || (multiplier == '0)) begin
            q_d     = '0;
            state_d = DONE;
          end
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      CALC: begin
        busy = 1'b1;
        // Arithmetic right shift of {S, Q}: S[0] drops into Q's top bit.
        a_d  = sum[dw:1];
        q_d  = {sum[0], q_q[dw-1:1]};
        if (last_step) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_robertson_mult_ctrl.sv
module tb_robertson_mult_ctrl;

  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [DW-1:0]   multiplicand;
  logic [DW-1:0]   multiplier;
  logic            busy;
  logic            done;
  logic [2*DW-1:0] product;

  robertson_mult_ctrl #(.dw(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected product, cycle number of the start edge, latency.
  int exp_prod[$];
  int exp_start[$];
  int exp_lat[$];
  int busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int lat_for(input logic [7:0] m, input logic [7:0] q);
`ifdef ROBERTSON_ZERO_SKIP_EN
    if ((m == 8'h00) || (q == 8'h00)) return 1;
`endif
    return DW + 1;
  endfunction

  // Monitor: latency is counted with the start edge as cycle 1's boundary,
  // i.e. done visible in the cycle following edge (start + lat - 1).
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_prod.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done product=%0h at cycle %0d", product, cyc);
        end else begin
          int p, s, l;
          p = exp_prod.pop_front();
          s = exp_start.pop_front();
          l = exp_lat.pop_front();
          chk("product", 32'(product), 32'(p));
          chk("done_latency", 32'(cyc - s + 1), 32'(l));
          chk("busy_cycles", 32'(busy_cnt), 32'(l - 1));
        end
        busy_cnt = 0;
      end
    end
  end

  // Called #1 after a rising edge; start is sampled at the next edge.
  task automatic go(input logic [7:0] m, input logic [7:0] q, input int p, input bit push);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    if (push) begin
      exp_prod.push_back(p);
      exp_start.push_back(cyc + 1);
      exp_lat.push_back(lat_for(m, q));
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input int p);
    int n = 0;
    while (exp_prod.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_prod.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_prod.size());
      exp_prod.delete(); exp_start.delete(); exp_lat.delete();
    end else begin
      chk("product_hold", 32'(product), 32'(p));
      chk("busy_idle", 32'(busy), 32'(0));
    end
  endtask

  initial begin
    int s;
    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_product", 32'(product), 32'(0));

    // Basic signed products.
    go(8'd3,  8'd5,  16'h000F, 1'b1); wait_drain(16'h000F);
    go(8'hFD, 8'd5,  16'hFFF1, 1'b1); wait_drain(16'hFFF1);
    go(8'd5,  8'hFD, 16'hFFF1, 1'b1); wait_drain(16'hFFF1);
    go(8'h80, 8'h80, 16'h4000, 1'b1); wait_drain(16'h4000);
    go(8'h80, 8'h7F, 16'hC080, 1'b1); wait_drain(16'hC080);
    go(8'hFF, 8'hFF, 16'h0001, 1'b1); wait_drain(16'h0001);
    go(8'h7F, 8'h80, 16'hC080, 1'b1); wait_drain(16'hC080);

    // Start pulse during CALC (counter 3) with new operands is ignored.
    go(8'd3, 8'd5, 16'h000F, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    multiplicand = 8'd7;
    multiplier   = 8'd9;
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
    multiplicand = 8'd11;
    wait_drain(16'h000F);

    // Start held high through DONE: second op starts on the DONE edge.
    multiplicand = 8'd5;
    multiplier   = 8'hFD;
    start        = 1'b1;
    s = cyc + 1;
    exp_prod.push_back(16'hFFF1); exp_start.push_back(s); exp_lat.push_back(DW + 1);
    @(posedge clk); #1;
    multiplicand = 8'h80;
    multiplier   = 8'h80;
    exp_prod.push_back(16'h4000); exp_start.push_back(s + DW + 1); exp_lat.push_back(DW + 1);
    repeat (DW + 1) @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain(16'h4000);

    // Reset during CALC counter 4: abort, no done pulse.
    go(8'd3, 8'd5, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_product", 32'(product), 32'(0));
    repeat (12) @(posedge clk);
    #1;
    go(8'hFD, 8'd5, 16'hFFF1, 1'b1); wait_drain(16'hFFF1);

    // Zero operand.
    go(8'd0, 8'd7, 16'h0000, 1'b1); wait_drain(16'h0000);
    go(8'd9, 8'd0, 16'h0000, 1'b1); wait_drain(16'h0000);

    chk("queue_empty", 32'(exp_prod.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
